key_frame_loader: RTL and testbench

//  Serial key-frame receiver and key register for the c432 locked netlist (mux key p1..p4, XOR keys X_1..X_13).

---
 rtl/key_frame_loader.sv | 76 +++++++
 tb/tb_key_frame_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_frame_loader.sv
// key_frame_loader: hunts for a serial header, loads a parity-checked key into key_out, and locks out after repeated failures (ports: clk rst key_sen key_sdi -> key_out key_valid load_done load_err key_lock fail_cnt)
module key_frame_loader #(
  parameter int KEY_W = 17,
  parameter int HDR_W = 8,
  parameter logic [HDR_W-1:0] HDR = 8'hA5,
  parameter int MAX_FAIL = 3,
  parameter logic [KEY_W-1:0] KEY_RST = 17'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sen,
  input  logic             key_sdi,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             key_lock,
  output logic [1:0]       fail_cnt
);
  localparam int CW = $clog2(KEY_W + 1);
  typedef enum logic [2:0] {HUNT, SHIFT, PAR, CHECK, LOCK} state_t;
  state_t state, nxt;
  logic [HDR_W-1:0] win, win_nxt;
  logic [KEY_W-1:0] kbuf;
  logic [CW-1:0] cnt;
  logic [1:0] fail_inc;
  logic good, hit, lock_n, done_n, err_n;
  always_comb begin
    win_nxt = {key_sdi, win[HDR_W-1:1]};
    hit = key_sen && win_nxt == HDR;
    fail_inc = fail_cnt + 2'd1;
    lock_n = fail_inc == 2'(MAX_FAIL);
  end
  always_comb begin
    nxt = state;
    case (state)
      HUNT:    nxt = hit ? SHIFT : HUNT;
      SHIFT:   nxt = !key_sen ? (lock_n ? LOCK : HUNT) : cnt == CW'(KEY_W - 1) ? PAR : SHIFT;
      PAR:     nxt = !key_sen ? (lock_n ? LOCK : HUNT) : CHECK;
      CHECK:   nxt = good ? HUNT : lock_n ? LOCK : HUNT;
      default: nxt = LOCK;
    endcase
  end
  always_comb begin
    done_n = state == CHECK && good;
    err_n = (state == CHECK && !good) || ((state == SHIFT || state == PAR) && !key_sen);
  end
  assign key_lock = state == LOCK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      win <= '0;
      kbuf <= '0;
      cnt <= '0;
      good <= 1'b0;
      key_out <= KEY_RST;
      key_valid <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      fail_cnt <= 2'd0;
    end else begin
      state <= nxt;
      load_done <= done_n;
      load_err <= err_n;
      win <= (state != HUNT || hit) ? '0 : key_sen ? win_nxt : win;
      cnt <= state != SHIFT ? '0 : key_sen ? cnt + 1'b1 : cnt;
      if (state == SHIFT && key_sen) kbuf[cnt] <= key_sdi;
      if (state == PAR && key_sen) good <= key_sdi == ^kbuf;
      if (done_n) begin
        key_out <= kbuf;
        key_valid <= 1'b1;
      end
      fail_cnt <= done_n ? 2'd0 : err_n ? fail_inc : fail_cnt;
    end
  end
endmodule

// File: tb/tb_key_frame_loader.sv
// tb_key_frame_loader: randomized frame stimulus with a queue scoreboard and a pulse monitor
module tb_key_frame_loader;
  logic clk = 1'b0;
  logic rst, key_sen, key_sdi;
  logic [16:0] key_out;
  logic key_valid, load_done, load_err, key_lock;
  logic [1:0] fail_cnt;
  key_frame_loader dut (
    .clk(clk), .rst(rst), .key_sen(key_sen), .key_sdi(key_sdi),
    .key_out(key_out), .key_valid(key_valid), .load_done(load_done),
    .load_err(load_err), .key_lock(key_lock), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  typedef struct {
    bit done;
    logic [16:0] key;
    bit valid;
    int fail;
    bit lock;
    int at;
  } exp_t;
  exp_t q[$];
  bit hist[$];
  logic [7:0] hdr = 8'hA5;
  logic [7:0] a4 = 8'hA4;
  logic [16:0] m_key;
  bit m_valid, m_lock;
  int m_fail;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst && (load_done || load_err)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse done=%0b err=%0b at cycle %0d", load_done, load_err, cyc);
      end else begin
        x = q.pop_front();
        chk("pulse_done", load_done, x.done);
        chk("pulse_err", load_err, !x.done);
        chk("pulse_cycle", cyc, x.at);
        chk("pulse_key", key_out, x.key);
        chk("pulse_valid", key_valid, x.valid);
        chk("pulse_fail", fail_cnt, x.fail);
        chk("pulse_lock", key_lock, x.lock);
      end
    end
  end
  function automatic bit early(input logic [7:0] nb, input int nlen);
    bit s[$];
    bit m;
    s = hist;
    for (int i = 0; i < nlen; i++) s.push_back(nb[i]);
    for (int i = 0; i < 8; i++) s.push_back(hdr[i]);
    for (int i = 7; i < s.size() - 1; i++) begin
      m = 1;
      for (int j = 0; j < 8; j++) if (s[i - 7 + j] != hdr[j]) m = 0;
      if (m) return 1;
    end
    return 0;
  endfunction
  task automatic drive(input bit s, input bit d);
    @(negedge clk);
    key_sen = s;
    key_sdi = d;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0);
  endtask
  task automatic outcome(input bit ok, input logic [16:0] key, input int at);
    exp_t x;
    if (ok) begin
      m_key = key;
      m_valid = 1;
      m_fail = 0;
    end else begin
      m_fail++;
      if (m_fail == 3) m_lock = 1;
    end
    x.done = ok; x.key = m_key; x.valid = m_valid; x.fail = m_fail; x.lock = m_lock; x.at = at;
    q.push_back(x);
  endtask
  task automatic static_check(input string tag);
    chk({tag, "_key"}, key_out, m_key);
    chk({tag, "_valid"}, key_valid, m_valid);
    chk({tag, "_fail"}, fail_cnt, m_fail);
    chk({tag, "_lock"}, key_lock, m_lock);
    chk({tag, "_pending"}, q.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    key_sen = 0;
    key_sdi = 0;
    @(negedge clk);
    rst = 0;
    m_key = '0; m_valid = 0; m_lock = 0; m_fail = 0;
    q.delete();
    hist.delete();
    static_check("reset");
    chk("reset_done", load_done, 0);
    chk("reset_err", load_err, 0);
  endtask
  task automatic send_frame(input logic [7:0] nb, input int nlen, input logic [16:0] key,
                            input bit par, input int abort_at, input string tag);
    int e;
    for (int i = 0; i < nlen; i++) begin
      drive(1, nb[i]);
      hist.push_back(nb[i]);
    end
    for (int i = 0; i < 8; i++) drive(1, hdr[i]);
    hist.delete();
    for (int k = 0; k <= 17; k++) begin
      if (k == abort_at) begin
        drive(0, 0);
        if (!m_lock) outcome(0, key, cyc + 1);
        idle(3);
        static_check(tag);
        return;
      end
      drive(1, k < 17 ? key[k] : par);
      e = cyc + 1;
    end
    if (!m_lock) outcome(par == ^key, key, e + 1);
    idle(3);
    static_check(tag);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [16:0] k;
    logic [7:0] nb;
    int nlen, ab;
    bit p;
    rst = 1;
    key_sen = 0;
    key_sdi = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_key = '0; m_valid = 0; m_lock = 0; m_fail = 0;
    static_check("init");
    send_frame(0, 0, 17'h0B3C5, 1, -1, "t1_good");
    send_frame(0, 0, 17'h0B3C5, 0, -1, "t2_badpar");
    send_frame(0, 0, 17'h0B3C5, 1, 9, "t3_abort");
    send_frame(0, 0, 17'h1FFFF, 1, -1, "t3_good");
    repeat (3) send_frame(0, 0, 17'h0B3C5, 0, -1, "t4_bad");
    send_frame(0, 0, 17'h12345, ^17'h12345, -1, "t4_locked");
    do_reset();
    send_frame(0, 0, 17'h0B3C5, 1, -1, "t6_pre");
    for (int i = 0; i < 8; i++) drive(1, hdr[i]);
    for (int i = 0; i < 5; i++) drive(1, 1);
    do_reset();
    send_frame(0, 0, 17'h0B3C5, 1, -1, "t6_post");
    send_frame(8'b0000_0011, 3, 17'h00001, 1, -1, "t5_noise");
    for (int i = 0; i < 8; i++) begin
      drive(1, a4[i]);
      hist.push_back(a4[i]);
    end
    idle(4);
    static_check("t5_a4");
    repeat (60) begin
      if (m_lock) do_reset();
      nlen = $urandom_range(0, 7);
      nb = 8'($urandom);
      for (int t = 0; t < 20 && early(nb, nlen); t++) nb = 8'($urandom);
      if (early(nb, nlen)) begin
        do_reset();
        nlen = 0;
      end
      k = 17'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~^k : ^k;
      ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 17)) : -1;
      send_frame(nb, nlen, k, p, ab, "rnd");
    end
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
